// File: rtl/usb_phy_io.sv
// USB pad-side PHY front end: pad synchronisers, glitch filter and line-state decode,
// registered transmit drive, attach pull-ups, and bus-reset / suspend detection.
module usb_phy_io #(
    parameter int LOW_SPEED        = 1,
    parameter int SYNC_STAGES      = 2,
    parameter int FILTER_LEN       = 2,
    parameter int TX_GUARD         = 2,
    parameter int BUS_RESET_CYCLES = 37500,
    parameter int SUSPEND_CYCLES   = 45000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pad_dp,
    input  logic i_pad_dn,
    output logic o_pad_dp,
    output logic o_pad_dn,
    output logic o_pad_oe,
    output logic o_pu_dp,
    output logic o_pu_dn,
    input  logic i_usb_oe,
    input  logic i_usb_j_not_k,
    input  logic i_usb_se0,
    input  logic i_attach,
    output logic o_usb_j_not_k,
    output logic o_usb_se0,
    output logic o_usb_se1,
    output logic o_bus_reset,
    output logic o_suspend
);

    localparam logic LS      = (LOW_SPEED != 0);
    localparam logic IDLE_DN = LS;
    localparam logic IDLE_DP = ~LS;
    localparam int   HL      = (FILTER_LEN > 1) ? FILTER_LEN - 1 : 1;
    localparam int   GW      = (TX_GUARD > 0) ? $clog2(TX_GUARD + 1) : 1;
    localparam int   RW      = $clog2(BUS_RESET_CYCLES + 1);
    localparam int   SW      = $clog2(SUSPEND_CYCLES + 1);
    localparam logic [GW-1:0] GUARD_MAX = GW'(TX_GUARD);
    localparam logic [RW-1:0] RST_MAX   = RW'(BUS_RESET_CYCLES);
    localparam logic [SW-1:0] SUSP_MAX  = SW'(SUSPEND_CYCLES);

    logic [SYNC_STAGES-1:0] sync_dp_q, sync_dn_q;
    logic [HL-1:0]          hist_dp_q, hist_dn_q;
    logic                   sync_dp_s, sync_dn_s, win_eq_s;
    logic                   filt_j_q, filt_se0_q, filt_se1_q;
    logic                   filt_j_d, filt_se0_d, filt_se1_d;
    logic [GW-1:0]          guard_q, guard_d;
    logic                   forced_now_s, forced_nxt_s;
    logic                   pad_oe_q, pad_dp_q, pad_dn_q, pu_dp_q, pu_dn_q, attach_q;
    logic                   pad_dp_d, pad_dn_d;
    logic                   rx_j_q, rx_se0_q, rx_se1_q;
    logic [RW-1:0]          rst_cnt_q, rst_cnt_d;
    logic [SW-1:0]          susp_cnt_q, susp_cnt_d;
    logic                   bus_reset_q, suspend_q;

    assign sync_dp_s    = sync_dp_q[SYNC_STAGES-1];
    assign sync_dn_s    = sync_dn_q[SYNC_STAGES-1];
    assign forced_now_s = pad_oe_q | (guard_q != {GW{1'b0}});
    assign pad_dp_d     = i_usb_se0 ? 1'b0 : (LS ? ~i_usb_j_not_k : i_usb_j_not_k);
    assign pad_dn_d     = i_usb_se0 ? 1'b0 : (LS ? i_usb_j_not_k : ~i_usb_j_not_k);

    // Filter window = current synchroniser output plus FILTER_LEN-1 older samples,
    // so the decoded state lands exactly SYNC_STAGES + FILTER_LEN cycles after a pad change.
    always_comb begin
        win_eq_s = 1'b1;
        for (int i = 0; i < FILTER_LEN - 1; i++) begin
            win_eq_s = win_eq_s & (hist_dp_q[i] == sync_dp_s) & (hist_dn_q[i] == sync_dn_s);
        end
    end

    // Line-state decode; j_not_k keeps its last value across SE0/SE1.
    always_comb begin
        filt_j_d   = filt_j_q;
        filt_se0_d = filt_se0_q;
        filt_se1_d = filt_se1_q;
        if (win_eq_s) begin
            case ({sync_dp_s, sync_dn_s})
                2'b00: begin
                    filt_se0_d = 1'b1;
                    filt_se1_d = 1'b0;
                end
                2'b11: begin
                    filt_se0_d = 1'b0;
                    filt_se1_d = 1'b1;
                end
                default: begin
                    filt_se0_d = 1'b0;
                    filt_se1_d = 1'b0;
                    filt_j_d   = LS ? sync_dn_s : sync_dp_s;
                end
            endcase
        end else begin
            filt_j_d   = filt_j_q;
            filt_se0_d = filt_se0_q;
            filt_se1_d = filt_se1_q;
        end
    end

    // Guard window and the two idle-line counters.
    always_comb begin
        if (pad_oe_q) begin
            guard_d = GUARD_MAX;
        end else if (guard_q != {GW{1'b0}}) begin
            guard_d = guard_q - GW'(1);
        end else begin
            guard_d = {GW{1'b0}};
        end
        forced_nxt_s = i_usb_oe | (guard_d != {GW{1'b0}});

        if (!attach_q || forced_now_s || !rx_se0_q) begin
            rst_cnt_d = {RW{1'b0}};
        end else if (rst_cnt_q != RST_MAX) begin
            rst_cnt_d = rst_cnt_q + RW'(1);
        end else begin
            rst_cnt_d = rst_cnt_q;
        end

        if (!attach_q || forced_now_s || !rx_j_q || rx_se0_q || rx_se1_q) begin
            susp_cnt_d = {SW{1'b0}};
        end else if (susp_cnt_q != SUSP_MAX) begin
            susp_cnt_d = susp_cnt_q + SW'(1);
        end else begin
            susp_cnt_d = susp_cnt_q;
        end
    end

    // Receive-side state: synchronisers, filter history, decoded and guarded outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_dp_q   <= {SYNC_STAGES{IDLE_DP}};
            sync_dn_q   <= {SYNC_STAGES{IDLE_DN}};
            hist_dp_q   <= {HL{IDLE_DP}};
            hist_dn_q   <= {HL{IDLE_DN}};
            filt_j_q    <= 1'b1;
            filt_se0_q  <= 1'b0;
            filt_se1_q  <= 1'b0;
            guard_q     <= {GW{1'b0}};
            rx_j_q      <= 1'b1;
            rx_se0_q    <= 1'b0;
            rx_se1_q    <= 1'b0;
            rst_cnt_q   <= {RW{1'b0}};
            susp_cnt_q  <= {SW{1'b0}};
            bus_reset_q <= 1'b0;
            suspend_q   <= 1'b0;
        end else begin
            sync_dp_q <= {sync_dp_q[SYNC_STAGES-2:0], i_pad_dp};
            sync_dn_q <= {sync_dn_q[SYNC_STAGES-2:0], i_pad_dn};
            for (int i = HL - 1; i > 0; i--) begin
                hist_dp_q[i] <= hist_dp_q[i-1];
                hist_dn_q[i] <= hist_dn_q[i-1];
            end
            hist_dp_q[0] <= sync_dp_s;
            hist_dn_q[0] <= sync_dn_s;
            filt_j_q     <= filt_j_d;
            filt_se0_q   <= filt_se0_d;
            filt_se1_q   <= filt_se1_d;
            guard_q      <= guard_d;
            rx_j_q       <= forced_nxt_s | filt_j_d;
            rx_se0_q     <= ~forced_nxt_s & filt_se0_d;
            rx_se1_q     <= ~forced_nxt_s & filt_se1_d;
            rst_cnt_q    <= rst_cnt_d;
            susp_cnt_q   <= susp_cnt_d;
            bus_reset_q  <= i_attach & (rst_cnt_d == RST_MAX);
            suspend_q    <= i_attach & (susp_cnt_d == SUSP_MAX);
        end
    end

    // Transmit drive and attach pull-ups, one register stage from the core.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pad_oe_q <= 1'b0;
            pad_dp_q <= 1'b0;
            pad_dn_q <= 1'b0;
            pu_dp_q  <= 1'b0;
            pu_dn_q  <= 1'b0;
            attach_q <= 1'b0;
        end else begin
            pad_oe_q <= i_usb_oe;
            pad_dp_q <= pad_dp_d;
            pad_dn_q <= pad_dn_d;
            pu_dp_q  <= i_attach & ~LS;
            pu_dn_q  <= i_attach & LS;
            attach_q <= i_attach;
        end
    end

    assign o_pad_oe      = pad_oe_q;
    assign o_pad_dp      = pad_dp_q;
    assign o_pad_dn      = pad_dn_q;
    assign o_pu_dp       = pu_dp_q;
    assign o_pu_dn       = pu_dn_q;
    assign o_usb_j_not_k = rx_j_q;
    assign o_usb_se0     = rx_se0_q;
    assign o_usb_se1     = rx_se1_q;
    assign o_bus_reset   = bus_reset_q;
    assign o_suspend     = suspend_q;

endmodule

// File: tb/tb_usb_phy_io.sv
// Scoreboarded bench for usb_phy_io: a history-based reference model pushes the
// expected output vector each clock; a monitor pops and compares on the falling edge.
module tb_usb_phy_io;

    localparam int LS   = 1;
    localparam int SYNC = 2;
    localparam int FILT = 2;
    localparam int TXG  = 2;
    localparam int BRC  = 10;
    localparam int SPC  = 8;
    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic rst_n, pad_dp, pad_dn, usb_oe, usb_jk, usb_se0, attach;
    logic o_pad_dp, o_pad_dn, o_pad_oe, o_pu_dp, o_pu_dn;
    logic o_usb_j_not_k, o_usb_se0, o_usb_se1, o_bus_reset, o_suspend;

    always #5 clk = ~clk;

    usb_phy_io #(
        .LOW_SPEED(LS), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TX_GUARD(TXG),
        .BUS_RESET_CYCLES(BRC), .SUSPEND_CYCLES(SPC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_pad_dp(pad_dp), .i_pad_dn(pad_dn),
        .o_pad_dp(o_pad_dp), .o_pad_dn(o_pad_dn), .o_pad_oe(o_pad_oe),
        .o_pu_dp(o_pu_dp), .o_pu_dn(o_pu_dn), .i_usb_oe(usb_oe),
        .i_usb_j_not_k(usb_jk), .i_usb_se0(usb_se0), .i_attach(attach),
        .o_usb_j_not_k(o_usb_j_not_k), .o_usb_se0(o_usb_se0), .o_usb_se1(o_usb_se1),
        .o_bus_reset(o_bus_reset), .o_suspend(o_suspend)
    );

    // Per-cycle histories of what the design sampled, used by the reference model.
    logic       h_dp  [MAXC];
    logic       h_dn  [MAXC];
    logic       h_oe  [MAXC];
    logic       q_se0 [MAXC];
    logic       q_j   [MAXC];
    logic [9:0] exp_q [$];
    int         n_cmp  = 0;
    int         n_fail = 0;

    // Reference model: line state from the last FILT samples seen SYNC cycles ago,
    // guard = any oe in the last TXG+1 cycles, detectors = last N qualified cycles.
    initial begin : ref_model
        int   cyc;
        logic rst, forced, eq, all_se0, all_j, att;
        logic f_j, f_se0, f_se1, e_j, e_se0, e_se1, e_br, e_su, e_dp, e_dn;
        int   w;
        cyc = 0;
        f_j = 1'b1; f_se0 = 1'b0; f_se1 = 1'b0;
        forever begin
            @(posedge clk);
            rst       = !rst_n;
            att       = rst ? 1'b0 : attach;
            h_dp[cyc] = rst ? ((LS != 0) ? 1'b0 : 1'b1) : pad_dp;
            h_dn[cyc] = rst ? ((LS != 0) ? 1'b1 : 1'b0) : pad_dn;
            h_oe[cyc] = rst ? 1'b0 : usb_oe;
            if (rst) begin
                f_j = 1'b1; f_se0 = 1'b0; f_se1 = 1'b0;
            end else begin
                w = cyc - SYNC;
                if (w - FILT + 1 >= 0) begin
                    eq = 1'b1;
                    for (int k = 1; k < FILT; k++)
                        if (h_dp[w-k] != h_dp[w] || h_dn[w-k] != h_dn[w]) eq = 1'b0;
                    if (eq) begin
                        if (!h_dp[w] && !h_dn[w]) begin
                            f_se0 = 1'b1; f_se1 = 1'b0;
                        end else if (h_dp[w] && h_dn[w]) begin
                            f_se0 = 1'b0; f_se1 = 1'b1;
                        end else begin
                            f_se0 = 1'b0; f_se1 = 1'b0;
                            f_j = (LS != 0) ? h_dn[w] : h_dp[w];
                        end
                    end
                end
            end
            forced = 1'b0;
            for (int g = 0; g <= TXG; g++)
                if (cyc - g >= 0 && h_oe[cyc-g]) forced = 1'b1;
            e_j   = rst | forced | f_j;
            e_se0 = !rst && !forced && f_se0;
            e_se1 = !rst && !forced && f_se1;
            q_se0[cyc] = att && !forced && e_se0;
            q_j[cyc]   = att && !forced && e_j && !e_se0 && !e_se1;
            all_se0 = (cyc >= BRC);
            all_j   = (cyc >= SPC);
            for (int k = 1; k <= BRC; k++) if (cyc - k >= 0 && !q_se0[cyc-k]) all_se0 = 1'b0;
            for (int k = 1; k <= SPC; k++) if (cyc - k >= 0 && !q_j[cyc-k]) all_j = 1'b0;
            e_br = att && all_se0;
            e_su = att && all_j;
            e_dp = !rst && !usb_se0 && ((LS != 0) ? !usb_jk : usb_jk);
            e_dn = !rst && !usb_se0 && ((LS != 0) ? usb_jk : !usb_jk);
            exp_q.push_back({h_oe[cyc], e_dp, e_dn, (LS == 0) && att, (LS != 0) && att,
                             e_j, e_se0, e_se1, e_br, e_su});
            cyc++;
        end
    end

    // Monitor: the DUT presents a full output vector every cycle.
    initial begin : monitor
        logic [9:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {o_pad_oe, o_pad_dp, o_pad_dn, o_pu_dp, o_pu_dn,
                     o_usb_j_not_k, o_usb_se0, o_usb_se1, o_bus_reset, o_suspend};
                n_cmp++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL t=%0t outputs{oe,dp,dn,pudp,pudn,j,se0,se1,brst,susp}: got %b want %b",
                             $time, a, e);
                end
            end
        end
    end

    task automatic pads(input logic dp, input logic dn, input int n);
        pad_dp = dp;
        pad_dn = dn;
        repeat (n) @(negedge clk);
    endtask

    task automatic tx(input logic oe, input logic jk, input logic se0);
        usb_oe  = oe;
        usb_jk  = jk;
        usb_se0 = se0;
        @(negedge clk);
    endtask

    initial begin : stimulus
        int r, len;
        rst_n = 1'b0; pad_dp = 1'b0; pad_dn = 1'b1;
        usb_oe = 1'b0; usb_jk = 1'b1; usb_se0 = 1'b0; attach = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b1; attach = 1'b1;
        pads(1'b0, 1'b1, 12); pads(1'b1, 1'b0, 8); pads(1'b0, 1'b1, 8);
        pads(1'b0, 1'b0, 1);  pads(1'b0, 1'b1, 8);
        pads(1'b0, 1'b0, 3);  pads(1'b0, 1'b1, 8);
        pads(1'b0, 1'b0, 20); pads(1'b0, 1'b1, 6);
        attach = 1'b0;
        pads(1'b0, 1'b0, 20); pads(1'b0, 1'b1, 6);
        attach = 1'b1;
        tx(1'b1, 1'b0, 1'b0); tx(1'b1, 1'b1, 1'b0); tx(1'b1, 1'b0, 1'b1);
        tx(1'b1, 1'b0, 1'b1); tx(1'b1, 1'b1, 1'b0); tx(1'b0, 1'b1, 1'b0);
        pads(1'b0, 1'b1, 14); pads(1'b1, 1'b0, 2); pads(1'b0, 1'b1, 14);
        tx(1'b1, 1'b1, 1'b0); tx(1'b0, 1'b1, 1'b0); pads(1'b0, 1'b1, 6);
        for (int s = 0; s < 150; s++) begin
            r   = $urandom_range(0, 19);
            len = $urandom_range(1, 24);
            if (r < 14) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: pads(1'b0, 1'b1, len);
                    4, 5, 6:    pads(1'b1, 1'b0, len);
                    7, 8:       pads(1'b0, 1'b0, len);
                    default:    pads(1'b1, 1'b1, len);
                endcase
            end else if (r < 17) begin
                pad_dp = 1'b0; pad_dn = 1'b1;
                for (int b = 0; b < (len % 6) + 1; b++)
                    tx(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
                tx(1'b0, 1'b1, 1'b0);
            end else if (r < 19) begin
                attach = ~attach;
                pads(pad_dp, pad_dn, 3);
            end else begin
                rst_n = 1'b0;
                repeat (5) @(negedge clk);
                rst_n = 1'b1;
            end
        end
        pads(1'b0, 1'b1, 6);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
